// File: rtl/facto_seq_master.sv
`default_nettype none
// ============================================================================
//  Module      : facto_seq_master
//  Description : Bus-master sequencer for the factorial core. It takes one
//                operand on a valid/ready request port, programs the core
//                over its sel/wr/addr/din slave port, waits for the core's
//                completion interrupt, reads the 128-bit result, clears the
//                core, and returns the result on a valid/ready response port.
//                Only one request is in flight at a time.
//  Option      : FACTO_SEQ_MASTER_TIMEOUT_EN enables a watchdog in WAIT that
//                abandons the operation after TIMEOUT_CYCLES cycles and
//                returns rsp_err=1 with a zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module facto_seq_master #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           reset_n,
    // request port
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [63:0]    req_operand,
    // response port
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [127:0]   rsp_result,
    output logic           rsp_err,
    // core slave port
    output logic           m_sel,
    output logic           m_wr,
    output logic [15:0]    m_addr,
    output logic [63:0]    m_dout,
    input  logic [63:0]    m_din,
    input  logic           interrupt,
    // status
    output logic           busy
);

    // Core register offsets (64-bit registers, stride 8)
    localparam logic [15:0] OFF_OPSTART  = 16'h0000;
    localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFF_INTREN   = 16'h0018;
    localparam logic [15:0] OFF_OPERAND  = 16'h0020;
    localparam logic [15:0] OFF_RESULT_H = 16'h0028;
    localparam logic [15:0] OFF_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_IDLE    = 4'd1,
        S_W_OPND  = 4'd2,
        S_W_START = 4'd3,
        S_WAIT    = 4'd4,
        S_R_H     = 4'd5,
        S_R_L     = 4'd6,
        S_W_STOP  = 4'd7,
        S_W_CLR   = 4'd8,
        S_W_UNCLR = 4'd9,
        S_RESP    = 4'd10
    } state_t;

    state_t       state;
    logic [63:0]  operand_q;

`ifdef FACTO_SEQ_MASTER_TIMEOUT_EN
    localparam int                WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdog;
`else
    // Without the watchdog a result can never be flagged invalid.
    assign rsp_err = 1'b0;
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // The operand write takes its data straight from req_operand at accept;
    // operand_q keeps a copy of the operand for the whole operation.
    logic unused_opnd;
    assign unused_opnd = ^operand_q;

    // Sequencer: every branch sets the registered outputs for the state it
    // moves to, so bus signals are valid for exactly the cycle spent in a
    // bus state. Bus strobes default low each cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INIT;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            m_sel      <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= '0;
            m_dout     <= '0;
            busy       <= 1'b0;
            operand_q  <= '0;
`ifdef FACTO_SEQ_MASTER_TIMEOUT_EN
            rsp_err    <= 1'b0;
            wdog       <= '0;
`endif
        end else begin
            m_sel <= 1'b0;
            m_wr  <= 1'b0;
            case (state)
                S_INIT: begin
                    if (!m_sel) begin
                        // first cycle out of reset: issue intrEn=1
                        m_sel  <= 1'b1;
                        m_wr   <= 1'b1;
                        m_addr <= BASE_ADDR + OFF_INTREN;
                        m_dout <= 64'd1;
                        busy   <= 1'b1;
                    end else begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        operand_q <= req_operand;
                        state     <= S_W_OPND;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        m_sel     <= 1'b1;
                        m_wr      <= 1'b1;
                        m_addr    <= BASE_ADDR + OFF_OPERAND;
                        m_dout    <= req_operand;
`ifdef FACTO_SEQ_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end
                S_W_OPND: begin
                    state  <= S_W_START;
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= BASE_ADDR + OFF_OPSTART;
                    m_dout <= 64'd1;
                end
                S_W_START: begin
                    state <= S_WAIT;
`ifdef FACTO_SEQ_MASTER_TIMEOUT_EN
                    wdog  <= '0;
`endif
                end
                S_WAIT: begin
                    if (interrupt) begin
                        state  <= S_R_H;
                        m_sel  <= 1'b1;
                        m_addr <= BASE_ADDR + OFF_RESULT_H;
                    end
`ifdef FACTO_SEQ_MASTER_TIMEOUT_EN
                    else if (wdog == WD_LAST) begin
                        // give up: skip the reads, still stop and clear the core
                        state      <= S_W_STOP;
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        m_sel      <= 1'b1;
                        m_wr       <= 1'b1;
                        m_addr     <= BASE_ADDR + OFF_OPSTART;
                        m_dout     <= 64'd0;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                S_R_H: begin
                    rsp_result[127:64] <= m_din;
                    state  <= S_R_L;
                    m_sel  <= 1'b1;
                    m_addr <= BASE_ADDR + OFF_RESULT_L;
                end
                S_R_L: begin
                    rsp_result[63:0] <= m_din;
                    state  <= S_W_STOP;
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= BASE_ADDR + OFF_OPSTART;
                    m_dout <= 64'd0;
                end
                S_W_STOP: begin
                    state  <= S_W_CLR;
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= BASE_ADDR + OFF_OPCLEAR;
                    m_dout <= 64'd1;
                end
                S_W_CLR: begin
                    state  <= S_W_UNCLR;
                    m_sel  <= 1'b1;
                    m_wr   <= 1'b1;
                    m_addr <= BASE_ADDR + OFF_OPCLEAR;
                    m_dout <= 64'd0;
                end
                S_W_UNCLR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
